simon_round_engine: RTL and testbench

SIMON_ROUND_ENGINE -- requirements
Module: simon_round_engine

---
 rtl/simon_round_engine.sv | 109 ++++++++++
 tb/tb_simon_round_engine.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_round_engine.sv
// Iterative SIMON block-cipher round engine: one round per clock, key words
// supplied per round by an external scheduler. Define SIMON_DECRYPT_EN to add a mode port.
module simon_round_engine #(
    parameter int WORD_SIZE = 16,
    parameter int ROUNDS    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
`ifdef SIMON_DECRYPT_EN
    input  logic                   mode,
`endif
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*WORD_SIZE-1:0] blk_in,
    input  logic [WORD_SIZE-1:0]   key_in,
    output logic                   key_load,
    output logic [7:0]             round_count,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WORD_SIZE-1:0] blk_out
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [7:0] LAST_ROUND = 8'(ROUNDS);

    state_t               state;
    logic [WORD_SIZE-1:0] x, y;
    logic [WORD_SIZE-1:0] round_x, round_y;
    logic                 accept;
`ifdef SIMON_DECRYPT_EN
    logic                 decrypt;
`endif

    function automatic logic [WORD_SIZE-1:0] rol(input logic [WORD_SIZE-1:0] v, input int n);
        int s;
        s = n % WORD_SIZE;
        return (v << s) | (v >> ((WORD_SIZE - s) % WORD_SIZE));
    endfunction

    function automatic logic [WORD_SIZE-1:0] simon_f(input logic [WORD_SIZE-1:0] v);
        return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
    endfunction

    // NOTE: handshake outputs are combinational so the key scheduler loads on the
    // same edge that accepts the block and has round-1 key ready for the first RUN cycle.
    assign in_ready = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept   = in_valid && in_ready;
    assign key_load = accept;
    assign blk_out  = out_valid ? {x, y} : '0;

    always_comb begin
        round_x = y ^ simon_f(x) ^ key_in;
        round_y = x;
`ifdef SIMON_DECRYPT_EN
        if (decrypt) begin
            round_x = y;
            round_y = x ^ simon_f(y) ^ key_in;
        end
`endif
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; the datapath is reset too so no stale block can leak out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            round_count <= '0;
            out_valid   <= 1'b0;
`ifdef SIMON_DECRYPT_EN
            decrypt     <= 1'b0;
`endif
        end else if (accept) begin
            // Acceptance from IDLE or from DONE with the out handshake: no bubble.
            x           <= blk_in[2*WORD_SIZE-1:WORD_SIZE];
            y           <= blk_in[WORD_SIZE-1:0];
            round_count <= 8'd1;
            out_valid   <= 1'b0;
            state       <= RUN;
`ifdef SIMON_DECRYPT_EN
            decrypt     <= mode;
`endif
        end else begin
            case (state)
                RUN: begin
                    x <= round_x;
                    y <= round_y;
                    if (round_count == LAST_ROUND) begin
                        state       <= DONE;
                        round_count <= '0;
                        out_valid   <= 1'b1;
                    end else begin
                        round_count <= round_count + 8'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_round_engine.sv
// Self-checking bench for simon_round_engine: directed SIMON32/64 vectors plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_simon_round_engine;

    localparam int R = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic        in_valid, in_ready, key_load, out_valid, out_ready;
    logic [31:0] blk_in, blk_out;
    logic [15:0] key_in;
    logic [7:0]  round_count;

    logic        mode1;
    logic        in_valid1, in_ready1, key_load1, out_valid1, out_ready1;
    logic [31:0] blk_in1, blk_out1;
    logic [15:0] key_in1;
    logic [7:0]  round_count1;

    logic [15:0] key_tab [R];
    bit          rev = 1'b0;
    bit          cmp_en = 1'b0;
    int          passed = 0;
    int          total = 0;
    int          kl_count = 0;
    int          m_age = 0;
    logic [31:0] m_res = '0;

    always #5 clk = ~clk;

    simon_round_engine #(.WORD_SIZE(16), .ROUNDS(R)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef SIMON_DECRYPT_EN
        .mode(mode),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .blk_in(blk_in), .key_in(key_in),
        .key_load(key_load), .round_count(round_count), .out_valid(out_valid),
        .out_ready(out_ready), .blk_out(blk_out)
    );

    simon_round_engine #(.WORD_SIZE(16), .ROUNDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
`ifdef SIMON_DECRYPT_EN
        .mode(mode1),
`endif
        .in_valid(in_valid1), .in_ready(in_ready1), .blk_in(blk_in1), .key_in(key_in1),
        .key_load(key_load1), .round_count(round_count1), .out_valid(out_valid1),
        .out_ready(out_ready1), .blk_out(blk_out1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] rol16(input logic [15:0] v, input int n);
        return (v << n) | (v >> (16 - n));
    endfunction

    function automatic logic [15:0] ff(input logic [15:0] v);
        return (rol16(v, 1) & rol16(v, 8)) ^ rol16(v, 2);
    endfunction

    function automatic logic [15:0] round_key(input int i);
        return rev ? key_tab[R-i] : key_tab[i-1];
    endfunction

    // Whole-block reference: run all rounds at once with the keys the scheduler hands out.
    function automatic logic [31:0] model_result(input logic [31:0] blk, input bit dec);
        logic [15:0] x, y, t, k;
        x = blk[31:16];
        y = blk[15:0];
        for (int i = 1; i <= R; i++) begin
            k = round_key(i);
            if (dec) begin
                t = y;
                y = x ^ ff(y) ^ k;
                x = t;
            end else begin
                t = x;
                x = y ^ ff(x) ^ k;
                y = t;
            end
        end
        return {x, y};
    endfunction

    // SIMON32/64 key expansion (m=4, sequence z0).
    task automatic load_schedule(input logic [63:0] key);
        logic [61:0] z0;
        logic [15:0] tmp;
        z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
        key_tab[0] = key[15:0];
        key_tab[1] = key[31:16];
        key_tab[2] = key[47:32];
        key_tab[3] = key[63:48];
        for (int i = 4; i < R; i++) begin
            tmp = rol16(key_tab[i-1], 13) ^ key_tab[i-3];
            tmp = tmp ^ rol16(tmp, 15);
            key_tab[i] = 16'hFFFC ^ {15'b0, z0[61-(i-4)]} ^ key_tab[i-4] ^ tmp;
        end
    endtask

    always_comb begin
        key_in = 16'h0;
        if (round_count != 8'd0)
            key_in = rev ? key_tab[R-int'(round_count)] : key_tab[int'(round_count)-1];
    end

    always @(posedge clk) if (key_load) kl_count++;

    // Transaction model: m_age counts edges since acceptance (0 = idle).
    always @(posedge clk or negedge rst_n) begin : model
        bit acc;
        bit dec;
        if (!rst_n) begin
            m_age <= 0;
            m_res <= '0;
        end else begin
            acc = in_valid && (m_age == 0 || (m_age == R + 1 && out_ready));
            dec = 1'b0;
`ifdef SIMON_DECRYPT_EN
            dec = mode;
`endif
            if (acc) begin
                m_age <= 1;
                m_res <= model_result(blk_in, dec);
            end else if (m_age >= 1 && m_age <= R) begin
                m_age <= m_age + 1;
            end else if (m_age == R + 1 && out_ready) begin
                m_age <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            bit exp_run, exp_done, exp_ir;
            exp_run  = (m_age >= 1 && m_age <= R);
            exp_done = (m_age == R + 1);
            exp_ir   = rst_n && (m_age == 0 || (exp_done && out_ready));
            check("cmp_in_ready", 32'(in_ready), 32'(exp_ir));
            check("cmp_key_load", 32'(key_load), 32'(in_valid && exp_ir));
            check("cmp_round_count", 32'(round_count), exp_run ? 32'(m_age) : 32'd0);
            check("cmp_out_valid", 32'(out_valid), 32'(exp_done));
            check("cmp_blk_out", blk_out, exp_done ? m_res : 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_round(input int target);
        int n = 0;
        while (int'(round_count) != target && n < 100) begin
            step();
            n++;
        end
        check("wait_round", 32'(round_count), 32'(target));
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        check("wait_out_valid", 32'(out_valid), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int kl0;
        rst_n = 1'b0; in_valid = 1'b1; blk_in = 32'h65656877; out_ready = 1'b0; mode = 1'b0;
        in_valid1 = 1'b0; blk_in1 = '0; out_ready1 = 1'b1; key_in1 = '0; mode1 = 1'b0;
        load_schedule(64'h1918_1110_0908_0100);
        check("ref_encrypt", model_result(32'h65656877, 1'b0), 32'hC69BE9BB);
        rev = 1'b1;
        check("ref_decrypt", model_result(32'hC69BE9BB, 1'b1), 32'h65656877);
        rev = 1'b0;

        #12;
        check("rst_round_count", 32'(round_count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_blk_out", blk_out, 32'd0);
        check("rst_key_load", 32'(key_load), 32'd0);
        cmp_en = 1'b1;

        // First edge after release accepts; out_ready low to hold the result.
        rst_n = 1'b1;
        kl0 = kl_count;
        step();
        in_valid = 1'b0;
        check("first_accept_rc", 32'(round_count), 32'd1);
        n = 1;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        check("latency_edges", 32'(n), 32'(R + 1));
        check("enc_result", blk_out, 32'hC69BE9BB);
        check("key_load_pulses", 32'(kl_count - kl0), 32'd1);

        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_blk_out", blk_out, 32'hC69BE9BB);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1; in_valid = 1'b1; blk_in = 32'h65656877;
        #1;
        check("done_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("no_bubble_rc", 32'(round_count), 32'd1);
        check("no_bubble_ov", 32'(out_valid), 32'd0);

        wait_round(5);
        in_valid = 1'b1; blk_in = $urandom;
        step();
        in_valid = 1'b0;
        check("ignored_in_valid_rc", 32'(round_count), 32'd6);
        wait_out(n);
        check("ignored_result", blk_out, 32'hC69BE9BB);

        in_valid = 1'b1; blk_in = 32'h65656877;
        step();
        in_valid = 1'b0;
        wait_round(17);
        rst_n = 1'b0; in_valid = 1'b1;
        #1;
        check("midrun_rst_ov", 32'(out_valid), 32'd0);
        check("midrun_rst_blk", blk_out, 32'd0);
        check("midrun_rst_rc", 32'(round_count), 32'd0);
        check("midrun_rst_kl", 32'(key_load), 32'd0);
        step();
        rst_n = 1'b1;
        kl0 = kl_count;
        step();
        in_valid = 1'b0;
        wait_out(n);
        check("after_rst_result", blk_out, 32'hC69BE9BB);
        check("after_rst_pulses", 32'(kl_count - kl0), 32'd1);

        for (int i = 0; i < 700; i++) begin
            step();
            if (m_age == 0 && $urandom_range(3) == 0) begin
                load_schedule({$urandom, $urandom});
`ifdef SIMON_DECRYPT_EN
                rev = $urandom_range(1) == 1;
`endif
            end
            in_valid  = $urandom_range(1) == 1;
            blk_in    = $urandom;
            out_ready = $urandom_range(2) != 0;
`ifdef SIMON_DECRYPT_EN
            mode = $urandom_range(1) == 1;
`endif
        end
        in_valid = 1'b0; out_ready = 1'b1; mode = 1'b0;
        n = 0;
        while (m_age != 0 && n < 100) begin
            step();
            n++;
        end
        check("drain_idle", 32'(round_count | {7'b0, out_valid}), 32'd0);

`ifdef SIMON_DECRYPT_EN
        load_schedule(64'h1918_1110_0908_0100);
        rev = 1'b1; mode = 1'b1; in_valid = 1'b1; blk_in = 32'hC69BE9BB;
        step();
        in_valid = 1'b0; mode = 1'b0;
        wait_out(n);
        check("dec_result", blk_out, 32'h65656877);
        step();
        rev = 1'b0;
`endif

        in_valid1 = 1'b1; blk_in1 = 32'h0001_0000;
        #1;
        check("r1_key_load", 32'(key_load1), 32'd1);
        step();
        in_valid1 = 1'b0;
        check("r1_rc", 32'(round_count1), 32'd1);
        check("r1_ov_early", 32'(out_valid1), 32'd0);
        step();
        check("r1_ov", 32'(out_valid1), 32'd1);
        check("r1_result", blk_out1, 32'h0004_0001);
        check("r1_rc_done", 32'(round_count1), 32'd0);
        step();
        check("r1_ov_after", 32'(out_valid1), 32'd0);
        check("r1_blk_after", blk_out1, 32'd0);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
